// File: rtl/axis_gain_meter.sv
// axis_gain_meter: frame-aligned attenuation/mute stage on a stereo AXI-Stream
// with a single registered output slice and a thermometer peak-level meter.
module axis_gain_meter #(
  parameter int width_p       = 24,
  parameter int peak_window_p = 1024
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic [width_p-1:0] s_data_i,
  input  logic               s_valid_i,
  output logic               s_ready_o,
  input  logic               s_last_i,
  output logic [width_p-1:0] m_data_o,
  output logic               m_valid_o,
  input  logic               m_ready_i,
  output logic               m_last_o,
  input  logic               vol_up_i,
  input  logic               vol_down_i,
  input  logic               mute_i,
  output logic [2:0]         atten_o,
  output logic               muted_o,
  output logic [4:0]         level_o
);
  localparam int cnt_w = peak_window_p > 1 ? $clog2(peak_window_p) : 1;
  localparam logic [cnt_w-1:0] cnt_last = cnt_w'(peak_window_p - 1);
  localparam logic [width_p-2:0] mag_max = '1;
  logic                      up_prev_q, dn_prev_q, mu_prev_q;
  logic [2:0]                atten_q, atten_d, att_act_q, att_act_d;
  logic                      muted_q, muted_d, mute_act_q, mute_act_d;
  logic [width_p-1:0]        m_data_q, m_data_d;
  logic                      m_valid_q, m_valid_d, m_last_q, m_last_d;
  logic [width_p-2:0]        peak_q, peak_d;
  logic [cnt_w-1:0]          cnt_q, cnt_d;
  logic [4:0]                level_q, level_d;
  logic                      up_e, dn_e, mu_e, acc, acc_last, win_end;
  logic signed [width_p-1:0] shifted;
  logic [width_p-1:0]        proc, neg;
  logic [width_p-2:0]        mag, pk_max;
  logic [4:0]                lvl;
  assign s_ready_o = reset_n_i & (~m_valid_q | m_ready_i);
  assign m_data_o  = m_data_q;
  assign m_valid_o = m_valid_q;
  assign m_last_o  = m_last_q;
  assign atten_o   = atten_q;
  assign muted_o   = muted_q;
  assign level_o   = level_q;
  always_comb begin
    up_e     = vol_up_i & ~up_prev_q;
    dn_e     = vol_down_i & ~dn_prev_q;
    mu_e     = mute_i & ~mu_prev_q;
    acc      = s_valid_i & s_ready_o;
    acc_last = acc & s_last_i;
    win_end  = acc_last & (cnt_q == cnt_last);
    shifted  = $signed(s_data_i) >>> att_act_q;
    proc     = mute_act_q ? '0 : shifted;
    neg      = -proc;
    // negating the most-negative value wraps to itself, so clamp it
    mag      = proc[width_p-1] ? (neg[width_p-1] ? mag_max : neg[width_p-2:0]) : proc[width_p-2:0];
    pk_max   = mag > peak_q ? mag : peak_q;
    lvl      = '0;
    for (int k = 0; k < 5; k++) lvl[k] = |(pk_max >> (width_p - 6 + k));
    atten_d    = (dn_e & ~up_e & ~&atten_q) ? atten_q + 3'd1 :
                 (up_e & ~dn_e & |atten_q)  ? atten_q - 3'd1 : atten_q;
    muted_d    = muted_q ^ mu_e;
    att_act_d  = acc_last ? atten_q : att_act_q;
    mute_act_d = acc_last ? muted_q : mute_act_q;
    m_data_d   = acc ? proc : m_data_q;
    m_last_d   = acc ? s_last_i : m_last_q;
    m_valid_d  = acc | (m_valid_q & ~m_ready_i);
    peak_d     = win_end ? '0 : acc ? pk_max : peak_q;
    cnt_d      = win_end ? '0 : acc_last ? cnt_q + cnt_w'(1) : cnt_q;
    level_d    = win_end ? lvl : level_q;
  end
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      up_prev_q  <= 1'b1;
      dn_prev_q  <= 1'b1;
      mu_prev_q  <= 1'b1;
      atten_q    <= '0;
      muted_q    <= 1'b0;
      att_act_q  <= '0;
      mute_act_q <= 1'b0;
      m_data_q   <= '0;
      m_valid_q  <= 1'b0;
      m_last_q   <= 1'b0;
      peak_q     <= '0;
      cnt_q      <= '0;
      level_q    <= '0;
    end else begin
      up_prev_q  <= vol_up_i;
      dn_prev_q  <= vol_down_i;
      mu_prev_q  <= mute_i;
      atten_q    <= atten_d;
      muted_q    <= muted_d;
      att_act_q  <= att_act_d;
      mute_act_q <= mute_act_d;
      m_data_q   <= m_data_d;
      m_valid_q  <= m_valid_d;
      m_last_q   <= m_last_d;
      peak_q     <= peak_d;
      cnt_q      <= cnt_d;
      level_q    <= level_d;
    end
  end
endmodule

// File: tb/tb_axis_gain_meter.sv
// tb_axis_gain_meter: directed vector table, corner sequences and randomized
// back-pressure traffic checked against a frame-level gain/meter model.
module tb_axis_gain_meter;
  logic        clk = 1'b0, rst_n = 1'b1;
  logic [23:0] s_data = '0, m_data;
  logic        s_valid = 1'b0, s_ready, s_last = 1'b0;
  logic        m_valid, m_ready = 1'b1, m_last;
  logic        vol_up = 1'b0, vol_down = 1'b0, mute_in = 1'b0;
  logic [2:0]  atten;
  logic        muted;
  logic [4:0]  level;
  int          n_chk = 0, n_fail = 0, n_acc = 0;

  axis_gain_meter #(.width_p(24), .peak_window_p(4)) dut (
    .clk_i(clk), .reset_n_i(rst_n),
    .s_data_i(s_data), .s_valid_i(s_valid), .s_ready_o(s_ready), .s_last_i(s_last),
    .m_data_o(m_data), .m_valid_o(m_valid), .m_ready_i(m_ready), .m_last_o(m_last),
    .vol_up_i(vol_up), .vol_down_i(vol_down), .mute_i(mute_in),
    .atten_o(atten), .muted_o(muted), .level_o(level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: requested/active gain, expected output queue, meter window
  logic [24:0] q[$];
  logic [24:0] ent, held;
  logic [4:0]  m_lvl;
  logic        stall_prev, p_up, p_dn, p_mu, e_up, e_dn, e_mu;
  int          m_att, m_mute, a_act, mu_act, peak, frames, v, e_i, mg;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_m_valid", m_valid, 0);
      chk("rst_m_data", m_data, 0);
      chk("rst_m_last", m_last, 0);
      chk("rst_atten", atten, 0);
      chk("rst_muted", muted, 0);
      chk("rst_level", level, 0);
      chk("rst_s_ready", s_ready, 0);
      q.delete();
      m_att = 0; m_mute = 0; a_act = 0; mu_act = 0; peak = 0; frames = 0; m_lvl = '0;
      p_up = 1'b1; p_dn = 1'b1; p_mu = 1'b1; stall_prev = 1'b0;
    end else begin
      chk("s_ready", s_ready, !m_valid || m_ready);
      chk("m_valid_vs_queue", m_valid, q.size() != 0);
      chk("atten_o", atten, m_att);
      chk("muted_o", muted, m_mute);
      chk("level_o", level, m_lvl);
      if (stall_prev) begin
        chk("hold_data", m_data, held[23:0]);
        chk("hold_last", m_last, held[24]);
      end
      if (m_valid && m_ready && q.size() != 0) begin
        ent = q.pop_front();
        chk("out_data", m_data, ent[23:0]);
        chk("out_last", m_last, ent[24]);
      end
      if (s_valid && s_ready) begin
        n_acc++;
        v   = int'($signed(s_data));
        e_i = mu_act != 0 ? 0 : v >>> a_act;
        q.push_back({s_last, e_i[23:0]});
        mg  = e_i < 0 ? (e_i == -8388608 ? 8388607 : -e_i) : e_i;
        if (mg > peak) peak = mg;
        if (s_last) begin
          frames++;
          if (frames == 4) begin
            for (int k = 0; k < 5; k++) m_lvl[k] = peak >= (1 << (18 + k));
            peak = 0; frames = 0;
          end
          a_act = m_att; mu_act = m_mute;
        end
      end
      e_up = vol_up && !p_up; e_dn = vol_down && !p_dn; e_mu = mute_in && !p_mu;
      if (e_dn && !e_up && m_att < 7) m_att++;
      if (e_up && !e_dn && m_att > 0) m_att--;
      if (e_mu) m_mute = 1 - m_mute;
      p_up = vol_up; p_dn = vol_down; p_mu = mute_in;
      stall_prev = m_valid && !m_ready;
      held = {m_last, m_data};
    end
  end

  typedef struct {
    logic v; logic [23:0] d; logic l; logic up, dn, mu;
    logic ev; logic [23:0] ed; logic el; logic [2:0] ea; logic em;
  } vec_t;
  vec_t tv [22];

  task automatic tick(); @(posedge clk); #1; endtask

  task automatic drive(input logic vv, input logic [23:0] dd, input logic ll,
                       input logic up, input logic dn, input logic mu);
    s_valid = vv; s_data = dd; s_last = ll; vol_up = up; vol_down = dn; mute_in = mu;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0);
    m_ready = 1'b1;
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic frame(input logic [23:0] l, input logic [23:0] r);
    drive(1, l, 0, 0, 0, 0); tick();
    drive(1, r, 1, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0);
  endtask

  task automatic pulse(input logic up, input logic dn);
    drive(0, 0, 0, up, dn, 0); tick();
    drive(0, 0, 0, 0, 0, 0); tick();
  endtask

  initial begin
    tv[0]  = '{1, 24'h123456, 0, 0, 0, 0, 1, 24'h123456, 0, 0, 0};
    tv[1]  = '{1, 24'hF00000, 1, 0, 0, 0, 1, 24'hF00000, 1, 0, 0};
    tv[2]  = '{1, 24'h400000, 0, 0, 0, 0, 1, 24'h400000, 0, 0, 0};
    tv[3]  = '{0, 24'h000000, 0, 0, 1, 0, 0, 24'h000000, 0, 1, 0};
    tv[4]  = '{0, 24'h000000, 0, 0, 0, 0, 0, 24'h000000, 0, 1, 0};
    tv[5]  = '{0, 24'h000000, 0, 0, 1, 0, 0, 24'h000000, 0, 2, 0};
    tv[6]  = '{0, 24'h000000, 0, 0, 0, 0, 0, 24'h000000, 0, 2, 0};
    tv[7]  = '{1, 24'h400000, 1, 0, 0, 0, 1, 24'h400000, 1, 2, 0};
    tv[8]  = '{1, 24'h400000, 0, 0, 0, 0, 1, 24'h100000, 0, 2, 0};
    tv[9]  = '{1, 24'h800000, 1, 0, 0, 0, 1, 24'hE00000, 1, 2, 0};
    tv[10] = '{0, 24'h000000, 0, 0, 0, 1, 0, 24'h000000, 0, 2, 1};
    tv[11] = '{0, 24'h000000, 0, 0, 0, 0, 0, 24'h000000, 0, 2, 1};
    tv[12] = '{1, 24'h100000, 0, 0, 0, 0, 1, 24'h040000, 0, 2, 1};
    tv[13] = '{1, 24'h200000, 1, 0, 0, 0, 1, 24'h080000, 1, 2, 1};
    tv[14] = '{1, 24'h123456, 0, 0, 0, 0, 1, 24'h000000, 0, 2, 1};
    tv[15] = '{1, 24'h654321, 1, 0, 0, 0, 1, 24'h000000, 1, 2, 1};
    tv[16] = '{0, 24'h000000, 0, 0, 0, 1, 0, 24'h000000, 0, 2, 0};
    tv[17] = '{0, 24'h000000, 0, 0, 0, 0, 0, 24'h000000, 0, 2, 0};
    tv[18] = '{1, 24'h100000, 0, 0, 0, 0, 1, 24'h000000, 0, 2, 0};
    tv[19] = '{1, 24'h100000, 1, 0, 0, 0, 1, 24'h000000, 1, 2, 0};
    tv[20] = '{1, 24'h400000, 0, 0, 0, 0, 1, 24'h100000, 0, 2, 0};
    tv[21] = '{1, 24'hC00000, 1, 0, 0, 0, 1, 24'hF00000, 1, 2, 0};
    #1 rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 22; i++) begin
      drive(tv[i].v, tv[i].d, tv[i].l, tv[i].up, tv[i].dn, tv[i].mu);
      chk($sformatf("tv%0d_s_ready", i), s_ready, 1);
      tick();
      chk($sformatf("tv%0d_m_valid", i), m_valid, tv[i].ev);
      if (tv[i].ev) begin
        chk($sformatf("tv%0d_m_data", i), m_data, tv[i].ed);
        chk($sformatf("tv%0d_m_last", i), m_last, tv[i].el);
      end
      chk($sformatf("tv%0d_atten", i), atten, tv[i].ea);
      chk($sformatf("tv%0d_muted", i), muted, tv[i].em);
    end
    drive(0, 0, 0, 0, 0, 0); tick();
    for (int i = 0; i < 9; i++) pulse(0, 1);
    chk("sat_high", atten, 7);
    pulse(1, 1);
    chk("simultaneous", atten, 7);
    for (int i = 0; i < 8; i++) pulse(1, 0);
    chk("sat_low", atten, 0);
    begin
      int cyc = 0, a0 = n_acc;
      while (n_acc - a0 < 256 && cyc < 5000) begin
        drive($urandom_range(0, 9) < 7, 24'($urandom), ((n_acc - a0) % 2) == 1,
              $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0);
        m_ready = $urandom_range(0, 1) == 1;
        tick();
        cyc++;
      end
      if (cyc >= 5000) chk("rand_budget", n_acc - a0, 256);
    end
    drive(0, 0, 0, 0, 0, 0);
    m_ready = 1'b1;
    tick(); tick(); tick();
    chk("drain_empty", q.size(), 0);
    pulse(0, 1); pulse(0, 0);
    frame(24'h111111, 24'h222222);
    drive(1, 24'h400000, 0, 0, 0, 1); tick();
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0); tick();
    rst_n = 1'b1; tick();
    drive(1, 24'h400000, 0, 0, 0, 0); tick();
    chk("post_reset_data", m_data, 24'h400000);
    chk("post_reset_atten", atten, 0);
    do_reset();
    for (int i = 0; i < 4; i++) begin
      if (i == 3) chk("meter_before_window", level, 0);
      frame(24'h0C0000, 24'hFD0000);
    end
    chk("meter_0c0000", level, 5'b00011);
    for (int i = 0; i < 4; i++) frame(24'h800000, 24'h100000);
    chk("meter_fullscale", level, 5'b11111);
    for (int i = 0; i < 4; i++) frame(24'h000000, 24'h000000);
    chk("meter_silent", level, 5'b00000);
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
